imem_loader: RTL

Boot-time program loader that acts as the writer for the instruction memory's write port. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written sequentially through the memory's address, write-enable and write-data inputs. The loader holds the CPU in reset until a complete, error-free image has been written.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_byte_packer.sv | 33 +++
 rtl/imem_loader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
   localparam int unsigned LEN_W      = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR0  = 3'd1,
      HDR1  = 3'd2,
      DATA  = 3'd3,
      WRITE = 3'd4,
      CSUM  = 3'd5,
      DONE  = 3'd6
   } state_t;

   // States in which the loader offers rx_ready.
   function automatic logic is_rx_state(input state_t s);
      return (s == HDR0) || (s == HDR1) || (s == DATA) || (s == CSUM);
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer; word_out/full look ahead to include the byte being pushed.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              push,
   input  logic              clear,
   output logic [WORD_W-1:0] word_out,
   output logic              full
);

   localparam int unsigned HOLD_W = WORD_W - BYTE_W;

   logic [HOLD_W-1:0] shreg;
   logic [1:0]        cnt;

   // Newest byte enters at the top, so the first byte ends up in [7:0].
   assign word_out = {byte_in, shreg};
   assign full     = push && (cnt == 2'(WORD_BYTES - 1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (push) begin
         shreg <= word_out[WORD_W-1:BYTE_W];
         cnt   <= cnt + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader writing a length-prefixed byte stream into instruction memory.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        cpu_hold
);

   localparam int unsigned IDX_W = $clog2(DEPTH) + 1;

   state_t             state, state_next;
   logic [LEN_W-1:0]   len, len_next, n_hdr;
   logic [IDX_W-1:0]   idx, idx_next;
   logic               err_next;
   logic               xfer, push, clear, full;
   logic [WORD_W-1:0]  word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0]  csum, csum_next;
`endif

   assign xfer = rx_valid && rx_ready;

   byte_packer u_packer (
      .clk      (clk),
      .rst      (rst),
      .byte_in  (rx_byte),
      .push     (push),
      .clear    (clear),
      .word_out (word),
      .full     (full)
   );

   // Next-state and next-register logic.
   always_comb begin
      state_next = state;
      len_next   = len;
      idx_next   = idx;
      err_next   = err;
      push       = 1'b0;
      clear      = 1'b0;
      n_hdr      = {rx_byte, len[7:0]};
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_next  = csum;
`endif
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next = HDR0;
               len_next   = '0;
               idx_next   = '0;
               err_next   = 1'b0;
               clear      = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_next  = '0;
`endif
            end
         end
         HDR0: begin
            if (xfer) begin
               len_next[7:0] = rx_byte;
               state_next    = HDR1;
            end
         end
         HDR1: begin
            if (xfer) begin
               len_next = n_hdr;
               if (n_hdr == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_next = CSUM;
`else
                  state_next = DONE;
`endif
               end else if (32'(n_hdr) > 32'(DEPTH)) begin
                  state_next = DONE;
                  err_next   = 1'b1;
               end else begin
                  state_next = DATA;
               end
            end
         end
         DATA: begin
            if (xfer) begin
               push = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_next = csum ^ rx_byte;
`endif
               if (full) state_next = WRITE;
            end
         end
         WRITE: begin
            idx_next = idx + IDX_W'(1);
            if (LEN_W'(idx_next) == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_next = CSUM;
`else
               state_next = DONE;
`endif
            end else begin
               state_next = DATA;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM: begin
            if (xfer) begin
               err_next   = (rx_byte != csum);
               state_next = DONE;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   // State and registered outputs, all decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         len       <= '0;
         idx       <= '0;
         err       <= 1'b0;
         rx_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cpu_hold  <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         state     <= state_next;
         len       <= len_next;
         idx       <= idx_next;
         err       <= err_next;
         rx_ready  <= is_rx_state(state_next);
         busy      <= (state_next != IDLE) && (state_next != DONE);
         done      <= (state_next == DONE);
         cpu_hold  <= !((state_next == DONE) && !err_next);
         mem_we    <= (state_next == WRITE);
         if (state_next == WRITE) begin
            mem_addr  <= BASE_ADDR + (32'(idx) * 32'(WORD_BYTES));
            mem_wdata <= word;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum      <= csum_next;
`endif
      end
   end

endmodule
